// File: rtl/seq_shifter_right_8bit.sv
// Multi-cycle handshaked right shifter/rotator: logical, arithmetic or rotate, one bit per clock.
// Define SEQ_SHIFTER_DOUBLE_STEP_EN to move two positions per clock while at least two remain.
module seq_shifter_right_8bit #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;

    // One right step; a double step is two of these, which gives the same fill order.
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                               input logic [1:0] m,
                                               input logic s);
        logic fill;
        case (m)
            2'b01:   fill = s;
            2'b10:   fill = v[0];
            default: fill = 1'b0;
        endcase
        return {fill, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            mode_q  <= 2'b00;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d = in;
                    count_d = ctrl;
                    mode_d  = mode;
                    sign_d  = in[WIDTH-1];
                    state_d = (ctrl == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
`ifdef SEQ_SHIFTER_DOUBLE_STEP_EN
                if ({1'b0, count_q} >= (SHW+1)'(2)) begin
                    shreg_d = step1(step1(shreg_q, mode_q, sign_q), mode_q, sign_q);
                    count_d = count_q - SHW'(2);
                end else begin
                    shreg_d = step1(shreg_q, mode_q, sign_q);
                    count_d = count_q - SHW'(1);
                end
`else
                shreg_d = step1(shreg_q, mode_q, sign_q);
                count_d = count_q - SHW'(1);
`endif
                if (count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = shreg_q;

endmodule

// File: tb/tb_seq_shifter_right_8bit.sv
// Scoreboard bench for seq_shifter_right_8bit: directed cases, back-pressure, reset abort, random traffic.
module tb_seq_shifter_right_8bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic [2:0] ctrl;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] sb_q[$];

    seq_shifter_right_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .ctrl      (ctrl),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] k, input logic [1:0] m);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < int'(k); i++) begin
            case (m)
                2'b01:   r = {d[7], r[7:1]};
                2'b10:   r = {r[0], r[7:1]};
                default: r = {1'b0, r[7:1]};
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] k);
`ifdef SEQ_SHIFTER_DOUBLE_STEP_EN
        return (int'(k) + 1) / 2;
`else
        return int'(k);
`endif
    endfunction

    // Results are compared when the consumer side actually takes them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("result", dout, sb_q.pop_front());
        end
    end

    task automatic do_req(input logic [7:0] d, input logic [2:0] k, input logic [1:0] m,
                          input int hold, input bit pre_next);
        int         cyc;
        logic [7:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_wait", in_ready, 1);
        din = d; ctrl = k; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(model(d, k, m));
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat(k));
        held = dout;
        if (pre_next) begin
            din = 8'h3C; ctrl = 3'd1; mode = 2'b00; in_valid = 1'b1;
        end
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_out", dout, held);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        $display("req in=%02h ctrl=%0d mode=%0d hold=%0d lat=%0d out=%02h", d, k, m, hold, cyc, held);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; din = '0; ctrl = '0; mode = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", dout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(8'd128, 3'd4, 2'b00, 0, 1'b0);
        chk("logical_out_kept", dout, 8'd8);
        do_req(8'h80, 3'd2, 2'b01, 0, 1'b0);
        chk("arith_out_kept", dout, 8'hE0);
        do_req(8'h81, 3'd1, 2'b10, 0, 1'b0);
        chk("rot_out_kept", dout, 8'hC0);
        do_req(8'hF0, 3'd3, 2'b11, 0, 1'b0);
        chk("mode3_out_kept", dout, 8'h1E);
        do_req(8'd255, 3'd7, 2'b00, 3, 1'b1);
        chk("bp_out_kept", dout, 8'd1);
        do_req(8'h3C, 3'd1, 2'b00, 0, 1'b0);
        do_req(8'hA5, 3'd0, 2'b10, 0, 1'b0);
        chk("zero_out_kept", dout, 8'hA5);
        do_req(8'h80, 3'd3, 2'b01, 1, 1'b0);
        chk("arith3_out_kept", dout, 8'hF0);

        // Abort a shift in flight; nothing is pushed because no result may appear.
        din = 8'h80; ctrl = 3'd6; mode = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out", dout, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        #10 rst_n = 1'b1;
        $display("reset abort in=80 ctrl=6 out=%02h valid=%0d", dout, out_valid);
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        do_req(8'h40, 3'd1, 2'b00, 0, 1'b0);
        chk("rel_out_kept", dout, 8'h20);

        for (int i = 0; i < 20; i++) begin
            do_req(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), 1'b0);
        end

        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter_right_8bit.md
Name: seq_shifter_right_8bit

Overview:
- Multi-cycle, handshaked right shifter/rotator. It complements the combinational 8-bit barrel shifter.
- Shifts one bit position per clock, so area stays minimal on slow datapaths.
- Supports logical, arithmetic and rotate modes.
- Valid/ready on input and output, so it drops between a producer FIFO and a consumer without glue.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of 2, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in  in  WIDTH  operand
- ctrl  in  SHW  shift amount, 0..WIDTH-1
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low, port rst_n.
  - While rst_n=0: state=IDLE, out=0, out_valid=0, internal count=0, in_ready=1. Requests are ignored while rst_n=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
  - in_ready = (state==IDLE), combinational from the state register.
- Accept: on an edge with state==IDLE and in_valid=1, the block latches in into the shift register, ctrl into count, mode into mode_q and in[WIDTH-1] into sign_q.
  - ctrl==0: next state DONE, out=in.
  - ctrl!=0: next state SHIFT.
- SHIFT, each edge:
  - One-position right step. Count decrements.
  - Fill bit: logical 0; arithmetic sign_q; rotate the current LSB.
  - When the count reaches 0 on that edge, next state is DONE.
- Latency:
  - For ctrl=k≥1, out_valid rises after the k-th edge following the accept edge.
  - For k=0, out_valid rises after the accept edge itself.
  - Total busy time is k+1 cycles minimum before the next accept.
- DONE:
  - out and out_valid are held stable until an edge with out_ready=1; that edge moves the state to IDLE and clears out_valid.
  - out keeps its last value in IDLE; only out_valid qualifies it.
- Back-to-back: no accept during DONE. The next accept is possible on the first edge in IDLE.
- Mode 11 behaves exactly as 00.
- Inputs in, ctrl and mode are don't-care outside the accept edge. Changes during SHIFT or DONE have no effect.
- Reset mid-operation aborts immediately. No partial result is ever flagged valid.
- in_valid held high in DONE is not consumed until after the out handshake.

Optional Feature:
- Macro: SEQ_SHIFTER_DOUBLE_STEP_EN.
- Defined:
  - In SHIFT, when count≥2 the block shifts two positions per edge and subtracts 2 from the count. Otherwise it shifts one position.
  - Fill per mode: logical zeros; arithmetic sign_q×2; rotate the two LSBs moved to the top, in order.
  - Latency becomes ceil(k/2) edges after accept for k≥1. k=0 is unchanged.
- Undefined: strictly one position per edge, as above.
- Results are identical in both builds; only timing differs.

Test Plan:
- Logical shift: in=8'd128, ctrl=4, mode=00, out_ready=1 → out=8'd8, out_valid high after the 4th edge post-accept. in_ready=0 for those cycles.
- Arithmetic and rotate:
  - in=8'h80, ctrl=2, mode=01 → out=8'hE0.
  - Then in=8'h81, ctrl=1, mode=10 → out=8'hC0.
  - Then in=8'hF0, ctrl=3, mode=11 → out=8'h1E.
- Back-pressure: in=8'd255, ctrl=7, mode=00, out_ready=0 for 3 cycles after out_valid → out=8'd1 is held stable with out_valid=1. A new in_valid is not accepted until the edge after out_ready=1.
- Zero shift: in=8'hA5, ctrl=0, mode=10 → out=8'hA5 with out_valid after the accept edge. Immediate out_ready returns the block to IDLE the next cycle.
- Reset mid-operation: accept in=8'h80, ctrl=6; pull rst_n low asynchronously between edges 3 and 4 → out=0, out_valid=0 immediately. After release, in_ready=1 and a fresh request (8'h40, ctrl=1) yields 8'h20.
- With SEQ_SHIFTER_DOUBLE_STEP_EN defined: in=8'd255, ctrl=7, mode=00 → out=8'd1 after 4 edges. in=8'h80, ctrl=3, mode=01 → out=8'hF0 after 2 edges.
